// File: rtl/fp_div_post_norm_if.sv
// Handshake and data bundle between the divider core, the post-normalise
// stage and its downstream consumer. The slave modport is the stage itself.
interface fp_div_post_norm_if #(
    parameter int MANT_W = 27,
    parameter int EXP_W  = 10
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              in_sticky;
    logic [1:0]        in_special;
    logic              in_dbz;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic              out_overflow;
    logic              out_underflow;
    logic              out_inexact;
    logic              out_dbz;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_sticky, in_special, in_dbz,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_overflow, out_underflow, out_inexact, out_dbz
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_sticky, in_special, in_dbz,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_overflow, out_underflow, out_inexact, out_dbz
    );
endinterface

// File: rtl/fp_div_post_norm.sv
// Floating-point divider back end: normalises the raw quotient (stage 1),
// rounds to nearest-even and packs an IEEE-754 single with exception flags
// (stage 2). Both stages stall together when the output is held.
module fp_div_post_norm #(
    parameter int MANT_W = 27,
    parameter int EXP_W  = 10
) (
    input  logic               g_clk,
    input  logic               n_reset,
    fp_div_post_norm_if.slave  bus
);
    // One extra bit so the normalise decrement and round carry never wrap.
    localparam int XW = EXP_W + 1;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(32'sd1);
    localparam logic signed [XW-1:0] EXP_INF  = XW'(32'sd255);
    localparam logic signed [XW-1:0] EXP_ZERO = XW'(32'sd0);

    logic                     advance_s;

    logic signed [XW-1:0]     in_exp_ext_s;
    logic signed [XW-1:0]     e1_s;
    logic [MANT_W-1:0]        norm_mant_s;

    logic                     s1_valid_r;
    logic                     s1_sign_r;
    logic signed [XW-1:0]     s1_exp_r;
    logic [MANT_W-1:0]        s1_mant_r;
    logic                     s1_sticky_r;
    logic [1:0]               s1_special_r;
    logic                     s1_dbz_r;

    logic [22:0]              frac_s;
    logic                     guard_s;
    logic                     sticky_s;
    logic                     round_up_s;
    logic                     round_inexact_s;
    logic [23:0]              frac_sum_s;
    logic signed [XW-1:0]     e2_s;

    logic [31:0]              result_s;
    logic                     overflow_s;
    logic                     underflow_s;
    logic                     inexact_s;

    logic                     out_valid_r;
    logic [31:0]              out_result_r;
    logic                     out_overflow_r;
    logic                     out_underflow_r;
    logic                     out_inexact_r;
    logic                     out_dbz_r;

    // The whole pipe moves whenever the output slot is empty or being taken.
    assign advance_s     = !out_valid_r | bus.out_ready;
    assign bus.in_ready  = advance_s;

    // Stage 1: a quotient below 1.0 is shifted up one place to restore the hidden bit.
    always_comb begin
        in_exp_ext_s = {bus.in_exp[EXP_W-1], bus.in_exp};
        if (bus.in_mant[MANT_W-1] == 1'b0) begin
            norm_mant_s = {bus.in_mant[MANT_W-2:0], 1'b0};
            e1_s        = in_exp_ext_s - EXP_ONE;
        end else begin
            norm_mant_s = bus.in_mant;
            e1_s        = in_exp_ext_s;
        end
    end

    // Stage 1 register: captures the normalised operand when the pipe advances.
    always_ff @(posedge g_clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_valid_r   <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_exp_r     <= '0;
            s1_mant_r    <= '0;
            s1_sticky_r  <= 1'b0;
            s1_special_r <= 2'b00;
            s1_dbz_r     <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r   <= bus.in_valid;
            s1_sign_r    <= bus.in_sign;
            s1_exp_r     <= e1_s;
            s1_mant_r    <= norm_mant_s;
            s1_sticky_r  <= bus.in_sticky;
            s1_special_r <= bus.in_special;
            s1_dbz_r     <= bus.in_dbz;
        end
    end

    // Stage 2 rounding: nearest-even on guard bit, with lower bits and remainder as sticky.
    always_comb begin
        frac_s          = s1_mant_r[MANT_W-2:MANT_W-24];
        guard_s         = s1_mant_r[MANT_W-25];
        sticky_s        = (|s1_mant_r[MANT_W-26:0]) | s1_sticky_r;
        round_up_s      = guard_s & (sticky_s | frac_s[0]);
        round_inexact_s = guard_s | sticky_s;
        frac_sum_s      = {1'b0, frac_s} + {23'd0, round_up_s};
        if (frac_sum_s[23]) begin
            e2_s = s1_exp_r + EXP_ONE;
        end else begin
            e2_s = s1_exp_r;
        end
    end

    // Stage 2 packing: specials win, then exponent range, then the normal encoding.
    always_comb begin
        result_s    = 32'h0000_0000;
        overflow_s  = 1'b0;
        underflow_s = 1'b0;
        inexact_s   = 1'b0;
        case (s1_special_r)
            2'b11: begin
                result_s = 32'h7FC0_0000;
            end
            2'b10: begin
                result_s = {s1_sign_r, 8'hFF, 23'h00_0000};
            end
            2'b01: begin
                result_s = {s1_sign_r, 31'h0000_0000};
            end
            default: begin
                if (e2_s >= EXP_INF) begin
                    result_s   = {s1_sign_r, 8'hFF, 23'h00_0000};
                    overflow_s = 1'b1;
                    inexact_s  = 1'b1;
                end else if (e2_s <= EXP_ZERO) begin
                    // No subnormal support: anything below the normal range flushes to zero.
                    result_s    = {s1_sign_r, 31'h0000_0000};
                    underflow_s = 1'b1;
                    inexact_s   = 1'b1;
                end else begin
                    result_s  = {s1_sign_r, e2_s[7:0], frac_sum_s[22:0]};
                    inexact_s = round_inexact_s;
                end
            end
        endcase
    end

    // Output register: holds the presented result stable while downstream stalls.
    always_ff @(posedge g_clk or negedge n_reset) begin
        if (!n_reset) begin
            out_valid_r     <= 1'b0;
            out_result_r    <= 32'h0000_0000;
            out_overflow_r  <= 1'b0;
            out_underflow_r <= 1'b0;
            out_inexact_r   <= 1'b0;
            out_dbz_r       <= 1'b0;
        end else if (advance_s) begin
            out_valid_r     <= s1_valid_r;
            out_result_r    <= result_s;
            out_overflow_r  <= overflow_s;
            out_underflow_r <= underflow_s;
            out_inexact_r   <= inexact_s;
            out_dbz_r       <= s1_dbz_r;
        end
    end

    assign bus.out_valid     = out_valid_r;
    assign bus.out_result    = out_result_r;
    assign bus.out_overflow  = out_overflow_r;
    assign bus.out_underflow = out_underflow_r;
    assign bus.out_inexact   = out_inexact_r;
    assign bus.out_dbz       = out_dbz_r;
endmodule

// File: tb/tb_fp_div_post_norm.sv
// Scoreboard bench for fp_div_post_norm: expected results are queued when an
// input is accepted and checked by an independent monitor on the output side.
module tb_fp_div_post_norm;
    localparam int MANT_W = 27;
    localparam int EXP_W  = 10;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;   // {overflow, underflow, inexact, dbz}
        int          acc;
        bit          lat_chk;
    } exp_t;

    logic g_clk = 1'b0;
    logic n_reset;

    fp_div_post_norm_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

    fp_div_post_norm #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
        .g_clk   (g_clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 g_clk = ~g_clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t cur_exp;
    bit   lat_mode = 1'b0;
    bit   head_seen = 1'b0;
    bit   rnd_on = 1'b0;

    always @(posedge g_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic [3:0] flags);
        exp_t r;
        r.res = res; r.flags = flags; r.acc = 0; r.lat_chk = 1'b0;
        return r;
    endfunction

    // Reference: exact integer view of the quotient, rounded nearest-even.
    function automatic exp_t model(input bit s, input int e, input logic [26:0] m,
                                   input bit st, input logic [1:0] sp, input bit dz);
        exp_t   r;
        longint mm, keep, rem;
        int     ee;
        bit     up, inx;
        r = mk(32'h0, {3'b000, dz});
        if (sp == 2'b11) r.res = 32'h7FC00000;
        else if (sp == 2'b10) r.res = {s, 8'hFF, 23'h0};
        else if (sp == 2'b01) r.res = {s, 31'h0};
        else begin
            mm = longint'(m);
            ee = e;
            if (mm < 64'sh4000000) begin mm = mm * 2; ee = ee - 1; end
            keep = mm / 8;          // 24 bits incl. hidden one
            rem  = mm % 8;          // discarded bits; 4 is the exact half
            up   = (rem > 4) || (rem == 4 && (st || (keep % 2 == 1)));
            inx  = (rem != 0) || st;
            if (up) keep = keep + 1;
            if (keep == 64'sh1000000) begin keep = keep / 2; ee = ee + 1; end
            if (ee >= 255) begin
                r.res = {s, 8'hFF, 23'h0}; r.flags = {3'b101, dz};
            end else if (ee <= 0) begin
                r.res = {s, 31'h0}; r.flags = {3'b011, dz};
            end else begin
                r.res = {s, ee[7:0], keep[22:0]}; r.flags = {2'b00, inx, dz};
            end
        end
        return r;
    endfunction

    // Record the expectation for every accepted input.
    initial forever begin
        exp_t e;
        @(negedge g_clk);
        if (n_reset === 1'b1 && bus.in_valid && bus.in_ready) begin
            e = cur_exp;
            e.acc = cyc;
            e.lat_chk = lat_mode;
            sb_q.push_back(e);
        end
    end

    // Output monitor: compare presented results against the queue head.
    initial forever begin
        @(negedge g_clk);
        if (n_reset === 1'b1 && bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_valid: out_valid=1 with result %h, expected no output", bus.out_result);
            end else begin
                check("result", bus.out_result, sb_q[0].res);
                check("flags", {28'h0, bus.out_overflow, bus.out_underflow, bus.out_inexact, bus.out_dbz},
                      {28'h0, sb_q[0].flags});
                if (sb_q[0].lat_chk && !head_seen)
                    check("latency", cyc - sb_q[0].acc, 32'd2);
                head_seen = 1'b1;
                if (bus.out_ready) begin
                    void'(sb_q.pop_front());
                    head_seen = 1'b0;
                end else begin
                    check("in_ready_stall", {31'h0, bus.in_ready}, 32'h0);
                end
            end
        end
    end

    task automatic send(input bit s, input int e, input logic [26:0] m, input bit st,
                        input logic [1:0] sp, input bit dz, input exp_t ex);
        bit acc;
        acc = 1'b0;
        cur_exp = ex;
        bus.in_sign = s; bus.in_exp = e[9:0]; bus.in_mant = m; bus.in_sticky = st;
        bus.in_special = sp; bus.in_dbz = dz; bus.in_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge g_clk);
            acc = bus.in_ready;
            @(posedge g_clk);
            #1;
        end
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0, expected acceptance");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        bit s, st, dz;
        int e;
        logic [26:0] m;
        logic [1:0] sp;
        s  = 1'($urandom_range(0, 1));
        st = 1'($urandom_range(0, 1));
        dz = 1'($urandom_range(0, 1));
        m  = 27'($urandom_range(32'h07FFFFFF, 32'h02000001));
        if ($urandom_range(0, 3) == 0) m[2:0] = 3'b100;
        if ($urandom_range(0, 7) == 0) m[25:3] = '1;
        case ($urandom_range(0, 3))
            0: e = int'($urandom_range(0, 1023)) - 512;
            1: e = int'($urandom_range(0, 4)) - 1;
            2: e = 250 + int'($urandom_range(0, 6));
            default: e = int'($urandom_range(1, 254));
        endcase
        sp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        send(s, e, m, st, sp, dz, model(s, e, m, st, sp, dz));
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge g_clk);
        #1;
        check("drain_empty", sb_q.size(), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, {31'h0, bus.out_valid}, 32'h0);
        check({tag, "_result"}, bus.out_result, 32'h0);
        check({tag, "_flags"}, {28'h0, bus.out_overflow, bus.out_underflow, bus.out_inexact, bus.out_dbz}, 32'h0);
    endtask

    initial begin
        n_reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
        bus.in_sticky = 1'b0; bus.in_special = 2'b00; bus.in_dbz = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
        check_idle_outputs("reset");
        n_reset = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge g_clk);
        #1;

        // Directed cases, no backpressure, latency checked.
        lat_mode = 1'b1;
        send(1'b0, 128, 27'h6000000, 1'b0, 2'b00, 1'b0, mk(32'h40400000, 4'b0000));
        send(1'b0, 127, 27'h2AAAAAA, 1'b1, 2'b00, 1'b0, mk(32'h3F2AAAAB, 4'b0010));
        send(1'b0, 127, 27'h4000004, 1'b0, 2'b00, 1'b0, mk(32'h3F800000, 4'b0010));
        send(1'b0, 127, 27'h400000C, 1'b0, 2'b00, 1'b0, mk(32'h3F800002, 4'b0010));
        send(1'b0, 254, 27'h7FFFFFC, 1'b0, 2'b00, 1'b0, mk(32'h7F800000, 4'b1010));
        send(1'b1, 0,   27'h4000000, 1'b0, 2'b00, 1'b0, mk(32'h80000000, 4'b0110));
        send(1'b0, 100, 27'h5555555, 1'b1, 2'b11, 1'b0, mk(32'h7FC00000, 4'b0000));
        send(1'b0, 300, 27'h4000000, 1'b0, 2'b10, 1'b1, mk(32'h7F800000, 4'b0001));
        send(1'b1, 90,  27'h4000001, 1'b1, 2'b01, 1'b0, mk(32'h80000000, 4'b0000));
        drain();
        lat_mode = 1'b0;

        // Backpressure: three back-to-back inputs, output stalled for 3 cycles.
        bus.out_ready = 1'b0;
        fork
            begin
                repeat (3) send_rand();
            end
            begin
                repeat (3) @(posedge g_clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Randomised traffic with random downstream stalls.
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge g_clk);
                #1 bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge g_clk);
                #1;
            end
            send_rand();
        end
        rnd_on = 1'b0;
        repeat (2) @(posedge g_clk);
        #2 bus.out_ready = 1'b1;
        drain();

        // Reset with data in flight: nothing may come out afterwards.
        bus.out_ready = 1'b0;
        send_rand();
        send_rand();
        n_reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        sb_q.delete();
        head_seen = 1'b0;
        repeat (2) @(posedge g_clk);
        #1 n_reset = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge g_clk);
        #1;
        check("post_reset_valid", {31'h0, bus.out_valid}, 32'h0);

        // Pipe still works after reset.
        send(1'b0, 128, 27'h6000000, 1'b0, 2'b00, 1'b0, mk(32'h40400000, 4'b0000));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
